// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - scanned 4-digit active-low 7-segment driver with blink and blank slot
// Optional: SEG_LEADING_ZERO_BLANK_EN blanks digit 3 while hour_tens is zero.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 250000,
    parameter int BLINK_TICKS = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hour_tens,
    input  logic [3:0] hour_units,
    input  logic [3:0] min_tens,
    input  logic [3:0] min_units,
    input  logic       adjust,
    input  logic [1:0] blink_sel,
    input  logic       colon_en,
    output logic [6:0] segments,
    output logic [3:0] anode_active,
    output logic       dp
);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t          state, state_nxt;
    logic [RW-1:0]   rcnt;
    logic            tick;
    logic [1:0]      idx;
    logic [BW-1:0]   bcnt;
    logic            blink_phase;
    logic [3:0]      digit;
    logic [6:0]      dec;
    logic            in_group;
    logic            blank_digit;
    logic [6:0]      segments_nxt;
    logic [3:0]      anode_nxt;
    logic            dp_nxt;

    assign tick = (rcnt == RW'(REFRESH_DIV - 1));

    // Blink timer only runs in adjust mode, so leaving adjust restarts it in the visible phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt        <= '0;
            idx         <= 2'd3;
            bcnt        <= '0;
            blink_phase <= 1'b0;
        end else begin
            rcnt <= tick ? '0 : rcnt + RW'(1);
            if (tick) begin
                idx <= idx + 2'd1;
            end
            if (!adjust) begin
                bcnt        <= '0;
                blink_phase <= 1'b0;
            end else if (tick) begin
                if (bcnt == BW'(BLINK_TICKS - 1)) begin
                    bcnt        <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    bcnt <= bcnt + BW'(1);
                end
            end
        end
    end

    always_comb begin
        digit = min_units;
        case (idx)
            2'd0: digit = min_units;
            2'd1: digit = min_tens;
            2'd2: digit = hour_units;
            2'd3: digit = hour_tens;
            default: digit = min_units;
        endcase
    end

    always_comb begin
        dec = 7'b1111111;
        case (digit)
            4'd0: dec = 7'b1000000;
            4'd1: dec = 7'b1111001;
            4'd2: dec = 7'b0100100;
            4'd3: dec = 7'b0110000;
            4'd4: dec = 7'b0011001;
            4'd5: dec = 7'b0010010;
            4'd6: dec = 7'b0000010;
            4'd7: dec = 7'b1111000;
            4'd8: dec = 7'b0000000;
            4'd9: dec = 7'b0010000;
            default: dec = 7'b1111111;
        endcase
    end

    always_comb begin
        in_group = 1'b0;
        case (blink_sel)
            2'd0: in_group = 1'b0;
            2'd1: in_group = idx[1];
            2'd2: in_group = ~idx[1];
            2'd3: in_group = 1'b1;
            default: in_group = 1'b0;
        endcase
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    assign blank_digit = (adjust && blink_phase && in_group) ||
                         (idx == 2'd3 && hour_tens == 4'd0);
`else
    assign blank_digit = adjust && blink_phase && in_group;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_BLANK;
            segments     <= 7'h7F;
            anode_active <= 4'hF;
            dp           <= 1'b1;
        end else begin
            state        <= state_nxt;
            segments     <= segments_nxt;
            anode_active <= anode_nxt;
            dp           <= dp_nxt;
        end
    end

    // Digit content is sampled only in the BLANK cycle, so SHOW never glitches mid-digit.
    always_comb begin
        state_nxt    = state;
        segments_nxt = segments;
        anode_nxt    = anode_active;
        dp_nxt       = dp;
        if (tick) begin
            state_nxt    = ST_BLANK;
            segments_nxt = 7'h7F;
            anode_nxt    = 4'hF;
            dp_nxt       = 1'b1;
        end else begin
            case (state)
                ST_BLANK: begin
                    state_nxt    = ST_SHOW;
                    anode_nxt    = ~(4'b0001 << idx);
                    segments_nxt = blank_digit ? 7'h7F : dec;
                    dp_nxt       = ~(colon_en && idx == 2'd2);
                end
                ST_SHOW: begin
                    state_nxt = ST_SHOW;
                end
                default: begin
                    state_nxt = ST_BLANK;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver at REFRESH_DIV=4, BLINK_TICKS=2
module tb_seg7_scan_driver;
    localparam int DIV = 4;
    localparam int BT  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] hour_tens = 4'd1;
    logic [3:0] hour_units = 4'd2;
    logic [3:0] min_tens = 4'd3;
    logic [3:0] min_units = 4'd4;
    logic       adjust = 1'b0;
    logic [1:0] blink_sel = 2'd0;
    logic       colon_en = 1'b0;
    logic [6:0] segments;
    logic [3:0] anode_active;
    logic       dp;

    int errors = 0;
    int checks = 0;
    logic [11:0] exp_q[$];
    int   m_idx;
    int   m_bcnt;
    logic m_phase;

    seg7_scan_driver #(.REFRESH_DIV(DIV), .BLINK_TICKS(BT)) dut (
        .clk(clk), .rst(rst),
        .hour_tens(hour_tens), .hour_units(hour_units),
        .min_tens(min_tens), .min_units(min_units),
        .adjust(adjust), .blink_sel(blink_sel), .colon_en(colon_en),
        .segments(segments), .anode_active(anode_active), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                     tag, got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [11:0] expect_show(input int i);
        logic [3:0] d;
        logic [3:0] an;
        logic       grp;
        logic       blank;
        logic [6:0] seg;
        d   = (i == 0) ? min_units : (i == 1) ? min_tens : (i == 2) ? hour_units : hour_tens;
        an  = 4'hF;
        an[i] = 1'b0;
        grp = (blink_sel == 2'd3) || (blink_sel == 2'd1 && i >= 2) || (blink_sel == 2'd2 && i <= 1);
        blank = adjust && m_phase && grp;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (i == 3 && hour_tens == 4'd0) blank = 1'b1;
`endif
        seg = blank ? 7'h7F : dec7(d);
        return {an, seg, ~(colon_en && i == 2)};
    endfunction

    // Entered at the negedge just before a tick edge; covers one BLANK + three SHOW cycles.
    task automatic slot(input string tag);
        logic [11:0] w;
        m_idx = (m_idx + 1) % 4;
        if (!adjust) begin
            m_bcnt  = 0;
            m_phase = 1'b0;
        end else if (m_bcnt == BT - 1) begin
            m_bcnt  = 0;
            m_phase = ~m_phase;
        end else begin
            m_bcnt++;
        end
        exp_q.push_back(12'hFFF);
        w = expect_show(m_idx);
        repeat (DIV - 1) exp_q.push_back(w);
        repeat (DIV) begin
            @(negedge clk);
            check($sformatf("%s.d%0d", tag, m_idx), {anode_active, segments, dp}, exp_q.pop_front());
        end
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        @(negedge clk);
        check(tag, {anode_active, segments, dp}, 12'hFFF);
        rst     = 1'b0;
        m_idx   = 3;
        m_bcnt  = 0;
        m_phase = 1'b0;
        repeat (DIV - 1) @(negedge clk);
    endtask

    initial begin
        pulse_reset("reset");
        exp_q.push_back({4'b1110, 7'b0011001, 1'b1});
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("first_digit0", {anode_active, segments, dp}, exp_q.pop_front());
        repeat (DIV - 2) @(negedge clk);
        m_idx = 0;
        for (int i = 0; i < 3; i++) slot("scan1234");

        hour_units = 4'hB;
        for (int i = 0; i < 4; i++) slot("bcd_b");
        hour_units = 4'd2;

        adjust = 1'b1; blink_sel = 2'd1; colon_en = 1'b1;
        for (int i = 0; i < 9; i++) slot("blink_hours");
        blink_sel = 2'd2;
        for (int i = 0; i < 4; i++) slot("blink_mins");
        blink_sel = 2'd3;
        for (int i = 0; i < 4; i++) slot("blink_all");
        adjust = 1'b0;
        for (int i = 0; i < 4; i++) slot("adjust_off");

        colon_en = 1'b1; hour_tens = 4'd5; min_tens = 4'd9; min_units = 4'd7; hour_units = 4'd8;
        for (int i = 0; i < 4; i++) slot("colon");
        colon_en = 1'b0;

        while (m_idx != 0) slot("align");
        slot("pre_rst");
        pulse_reset("rst_mid_show");
        slot("after_rst");
        hour_tens = 4'd0; min_units = 4'd6;
        for (int i = 0; i < 4; i++) slot("lead_zero");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
